fp_mult_pipe: RTL and testbench

- 3-stage pipelined IEEE-754 single-precision multiplier.
- Sits directly upstream of the FP adder/subtractor in the radix-4 butterfly datapath. It multiplies butterfly operands by twiddle components and feeds the products to the adder inputs.
- Uses a valid/ready handshake with full back-pressure and carries a user tag alongside each result.

---
 rtl/fp_mult_pipe.sv | 138 +++++++++++++
 tb/tb_fp_mult_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined FP32 multiplier (flush-to-zero, saturating, no Inf/NaN) with valid/ready back-pressure.
// Define FP_MULT_RNE_EN for round-to-nearest-even in stage 3; the default build truncates.
module fp_mult_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      p,
    output logic [TAG_W-1:0] out_tag
);

`ifdef FP_MULT_RNE_EN
    localparam int PROD_LSB = 0;
`else
    localparam int PROD_LSB = 23;
`endif
    localparam int PROD_W = 48 - PROD_LSB;

    logic                    adv;
    logic                    vld_p0;
    logic                    vld_p1;
    logic                    sign_p0;
    logic                    zero_p0;
    logic signed [9:0]       exp_p0;
    logic [23:0]             siga_p0;
    logic [23:0]             sigb_p0;
    logic [TAG_W-1:0]        tag_p0;
    logic                    sign_p1;
    logic                    zero_p1;
    logic signed [9:0]       exp_p1;
    logic [47:PROD_LSB]      prod_p1;
    logic [TAG_W-1:0]        tag_p1;
    logic signed [9:0]       exp_n;
    logic [22:0]             man_n;
    logic [31:0]             p_next;

    // Boundary handling: zero flag and underflow give signed zero, overflow saturates to max finite.
    function automatic logic [31:0] sat_pack(input logic sign, input logic zero,
                                             input logic signed [9:0] exp_in,
                                             input logic [22:0] man);
        logic [31:0] r;
        if (zero || (exp_in <= 10'sd0))
            r = {sign, 31'b0};
        else if (exp_in >= 10'sd255)
            r = {sign, 8'hFE, 23'h7FFFFF};
        else
            r = {sign, exp_in[7:0], man};
        return r;
    endfunction

`ifdef FP_MULT_RNE_EN
    function automatic logic [23:0] rne_round(input logic [22:0] man, input logic guard,
                                              input logic sticky);
        return {1'b0, man} + {23'b0, guard & (sticky | man[0])};
    endfunction
`endif

    assign in_ready = ~(out_valid & ~out_ready);
    assign adv      = in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
        end
    end

    // Stage 1: unpack operands, flag zero/denormal inputs, form biased exponent sum
    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p0 <= a[31] ^ b[31];
            zero_p0 <= (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
            exp_p0  <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            siga_p0 <= {1'b1, a[22:0]};
            sigb_p0 <= {1'b1, b[22:0]};
            tag_p0  <= in_tag;
        end
    end

    // Stage 2: significand product; truncating builds keep only the bits normalization reads
    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p1 <= sign_p0;
            zero_p1 <= zero_p0;
            exp_p1  <= exp_p0;
            prod_p1 <= PROD_W'(({24'b0, siga_p0} * {24'b0, sigb_p0}) >> PROD_LSB);
            tag_p1  <= tag_p0;
        end
    end

    // Stage 3: normalize, optionally round, apply boundary rules and pack
`ifdef FP_MULT_RNE_EN
    logic        guard_n;
    logic        sticky_n;
    logic [23:0] man_r;
`endif

    always_comb begin
        exp_n = exp_p1;
        man_n = prod_p1[45:23];
        if (prod_p1[47]) begin
            exp_n = exp_p1 + 10'sd1;
            man_n = prod_p1[46:24];
        end
`ifdef FP_MULT_RNE_EN
        guard_n  = prod_p1[47] ? prod_p1[23] : prod_p1[22];
        sticky_n = prod_p1[47] ? (|prod_p1[22:0]) : (|prod_p1[21:0]);
        man_r    = rne_round(man_n, guard_n, sticky_n);
        if (man_r[23])
            exp_n = exp_n + 10'sd1;
        man_n = man_r[22:0];
`endif
        p_next = sat_pack(sign_p1, zero_p1, exp_n, man_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= 32'b0;
            out_tag <= '0;
        end else if (adv) begin
            p       <= p_next;
            out_tag <= tag_p1;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: latency, arithmetic corner cases, back-pressure and mid-flight reset.
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic [3:0]  out_tag;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;

`ifdef FP_MULT_RNE_EN
    localparam logic [31:0] RNE_P = 32'h3FC00002;
`else
    localparam logic [31:0] RNE_P = 32'h3FC00001;
`endif

    logic [31:0] st_b[6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] st_p[6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                             32'h41000000, 32'h41200000, 32'h41400000};

    fp_mult_pipe #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every transferred product must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("p", p, mon_e[31:0]);
                chk("out_tag", 32'(out_tag), 32'(mon_e[35:32]));
                n_out++;
            end
        end
    end

    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic [3:0] vt, input logic [31:0] vp);
        int g = 0;
        a = va;
        b = vb;
        in_tag = vt;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back({vt, vp});
            acc_cyc = cyc;
            n_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_p", p, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // single product, latency measured from the accepting cycle
        send(32'h40000000, 32'h40400000, 4'd3, 32'h40C00000);
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("latency", cyc - acc_cyc, 32'd3);
        wait_drain();

        // back-to-back arithmetic and boundary cases
        send(32'hBF800000, 32'h3F000000, 4'd1, 32'hBF000000);
        send(32'h3FC00000, 32'h3FC00000, 4'd2, 32'h40100000);
        send(32'h00000000, 32'h7F7FFFFF, 4'd4, 32'h00000000);
        send(32'h00800000, 32'h00800000, 4'd5, 32'h00000000);
        send(32'h7F000000, 32'hFF000000, 4'd6, 32'hFF7FFFFF);
        send(32'h3F800001, 32'h3FC00000, 4'd9, RNE_P);
        wait_drain();

        // back-pressure: six pairs, downstream stalls from the third cycle
        n_acc = 0;
        n_out = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h40000000, st_b[i], 4'(10 + i), st_p[i]);
            end
            begin
                int h = 0;
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                while (!out_valid && h < 20) begin
                    @(negedge clk);
                    h++;
                end
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (4) begin
                    @(negedge clk);
                    chk("hold_p", p, st_p[0]);
                end
                chk("hold_tag", 32'(out_tag), 32'd10);
                chk("held_count", n_acc, 32'd3);
                chk("held_no_out", n_out, 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("drain_count", n_out, 32'd6);

        // reset with two products in flight
        send(32'h3FC00000, 32'h3FC00000, 4'd1, 32'h40100000);
        send(32'h40000000, 32'h40400000, 4'd2, 32'h40C00000);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_p", p, 32'd0);
        exp_q.delete();
        n_out = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_stale_valid", 32'(out_valid), 32'd0);
        chk("no_stale_count", n_out, 32'd0);
        @(posedge clk);
        #1;
        send(32'h40000000, 32'h40400000, 4'd7, 32'h40C00000);
        wait_drain();
        chk("post_rst_count", n_out, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
